// File: rtl/game_draw_sequencer.sv
// Game screen draw sequencer.
// Per-round player dots and a timer-bar pixel are plotted until the timer
// expires. The screen is then cleared in raster order, and one result box per
// ranked slot is drawn.
// Output strobe: x, y and colour are meaningful only on cycles where plot=1.
// There is no ready/backpressure. The consumer must accept one pixel on every
// plot cycle.
module game_draw_sequencer #(
  parameter int NUM_PLAYERS = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int TIMER_ROW   = 119,
  parameter int BOX_W       = 5,
  parameter int BOX_H       = 7,
  parameter int BOX_X0      = 33,
  parameter int BOX_PITCH   = 30,
  parameter int BOX_Y0      = 42
) (
  input  logic                               CLOCK_50,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               tick,
  input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0]   pos,
  input  logic [NUM_PLAYERS*3-1:0]           pcolour,
  input  logic [NUM_PLAYERS*3-1:0]           rank,
  output logic [X_W-1:0]                     x,
  output logic [Y_W-1:0]                     y,
  output logic [2:0]                         colour,
  output logic                               plot,
  output logic                               game_started,
  output logic                               running,
  output logic                               done,
  output logic [2:0]                         dbg_state
);

  localparam int PW = X_W + Y_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PLAYER = 3'd1;
  localparam logic [2:0] S_TIMER  = 3'd2;
  localparam logic [2:0] S_CLEAR  = 3'd3;
  localparam logic [2:0] S_BOX    = 3'd4;
  localparam logic [2:0] S_END    = 3'd5;

  logic [2:0]     state_q, state_d;
  logic [2:0]     p_q, p_d;
  logic [X_W-1:0] timer_x_q, timer_x_d;
  logic           running_q, running_d;
  logic [X_W-1:0] cx_q, cx_d;
  logic [Y_W-1:0] cy_q, cy_d;
  logic [2:0]     k_q, k_d;
  logic [X_W-1:0] dx_q, dx_d;
  logic [Y_W-1:0] dy_q, dy_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [2:0]     colour_q, colour_d;
  logic           plot_q, plot_d;

  logic [PW-1:0]  pos_sel;
  logic [2:0]     rank_sel;
  logic [2:0]     box_colour;

  // Player slice p and rank slot k; both indices stay below NUM_PLAYERS.
  assign pos_sel  = pos[int'(p_q)*PW +: PW];
  assign rank_sel = rank[int'(k_q)*3 +: 3];

  // Colour of the player named by rank slot k; out-of-range ranks give black.
  always_comb begin
    box_colour = 3'b000;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (rank_sel == 3'(i)) box_colour = pcolour[i*3 +: 3];
    end
  end

  // Next-state, timer and pixel generation for every state.
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    timer_x_d = timer_x_q;
    running_d = running_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    k_d       = k_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    x_d       = '0;
    y_d       = '0;
    colour_d  = 3'b000;
    plot_d    = 1'b0;

    // Ticks only count while the game loop is active; the bar never wraps.
    if ((state_q == S_PLAYER || state_q == S_TIMER) && running_q && tick) begin
      if (timer_x_q == X_W'(SCREEN_W-2)) begin
        timer_x_d = X_W'(SCREEN_W-1);
        running_d = 1'b0;
      end else begin
        timer_x_d = timer_x_q + X_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_PLAYER;
          p_d       = 3'd0;
          timer_x_d = '0;
          running_d = 1'b1;
        end
      end
      S_PLAYER: begin
        plot_d   = 1'b1;
        x_d      = pos_sel[PW-1:Y_W];
        y_d      = pos_sel[Y_W-1:0];
        colour_d = pcolour[int'(p_q)*3 +: 3];
        if (p_q == 3'(NUM_PLAYERS-1)) begin
          state_d = S_TIMER;
          p_d     = 3'd0;
        end else begin
          p_d = p_q + 3'd1;
        end
      end
      S_TIMER: begin
        plot_d   = 1'b1;
        x_d      = timer_x_q;
        y_d      = Y_W'(TIMER_ROW);
        colour_d = 3'b111;
        // Uses the registered running so the round in flight always finishes.
        if (running_q) begin
          state_d = S_PLAYER;
          p_d     = 3'd0;
        end else begin
          state_d = S_CLEAR;
          cx_d    = '0;
          cy_d    = '0;
        end
      end
      S_CLEAR: begin
        plot_d   = 1'b1;
        x_d      = cx_q;
        y_d      = cy_q;
        colour_d = 3'b000;
        if (cx_q == X_W'(SCREEN_W-1)) begin
          cx_d = '0;
          if (cy_q == Y_W'(SCREEN_H-1)) begin
            state_d = S_BOX;
            cy_d    = '0;
            k_d     = 3'd0;
            dx_d    = '0;
            dy_d    = '0;
          end else begin
            cy_d = cy_q + Y_W'(1);
          end
        end else begin
          cx_d = cx_q + X_W'(1);
        end
      end
      S_BOX: begin
        plot_d   = 1'b1;
        x_d      = X_W'(BOX_X0) + X_W'(k_q) * X_W'(BOX_PITCH) + dx_q;
        y_d      = Y_W'(BOX_Y0) + dy_q;
        colour_d = box_colour;
        if (dx_q == X_W'(BOX_W-1)) begin
          dx_d = '0;
          if (dy_q == Y_W'(BOX_H-1)) begin
            dy_d = '0;
            if (k_q == 3'(NUM_PLAYERS-1)) begin
              state_d = S_END;
              k_d     = 3'd0;
            end else begin
              k_d = k_q + 3'd1;
            end
          end else begin
            dy_d = dy_q + Y_W'(1);
          end
        end else begin
          dx_d = dx_q + X_W'(1);
        end
      end
      S_END: begin
        // Terminal until reset; start and tick have no effect here.
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered pixel outputs; reset wins over everything.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= S_IDLE;
      p_q       <= 3'd0;
      timer_x_q <= '0;
      running_q <= 1'b1;
      cx_q      <= '0;
      cy_q      <= '0;
      k_q       <= 3'd0;
      dx_q      <= '0;
      dy_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= 3'b000;
      plot_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      timer_x_q <= timer_x_d;
      running_q <= running_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      k_q       <= k_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign colour       = colour_q;
  assign plot         = plot_q;
  assign running      = running_q;
  assign game_started = (state_q != S_IDLE);
  assign done         = (state_q == S_END);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_game_draw_sequencer.sv
// Directed bench for game_draw_sequencer: default 4-player instance plus a
// 2-player, 64x32 instance. Outputs are sampled 1 ns after each rising edge.
module tb_game_draw_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration instance
  logic        reset, start, tick;
  logic [59:0] pos;
  logic [11:0] pcolour, rank;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour, dbg_state;
  logic        plot, game_started, running, done;

  game_draw_sequencer dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .tick(tick),
    .pos(pos), .pcolour(pcolour), .rank(rank),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .game_started(game_started), .running(running), .done(done),
    .dbg_state(dbg_state)
  );

  // Small configuration instance
  logic        reset2, start2, tick2;
  logic [29:0] pos2;
  logic [5:0]  pcolour2, rank2;
  logic [7:0]  x2;
  logic [6:0]  y2;
  logic [2:0]  colour2, dbg_state2;
  logic        plot2, game_started2, running2, done2;

  game_draw_sequencer #(.NUM_PLAYERS(2), .SCREEN_W(64), .SCREEN_H(32)) dut2 (
    .CLOCK_50(clk), .reset(reset2), .start(start2), .tick(tick2),
    .pos(pos2), .pcolour(pcolour2), .rank(rank2),
    .x(x2), .y(y2), .colour(colour2), .plot(plot2),
    .game_started(game_started2), .running(running2), .done(done2),
    .dbg_state(dbg_state2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [18:0] got, exp;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; tick = 1'b1;
    step(); step();
    n_cmp++;
    if ({plot, x, y, colour} !== 19'd0) begin
      n_bad++; $display("FAIL reset_pixel: got %h expected 0", {plot, x, y, colour});
    end
    n_cmp++;
    if ({running, done, game_started, dbg_state} !== 6'b100_000) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 100000", {running, done, game_started, dbg_state});
    end
    reset = 1'b0; start = 1'b0; tick = 1'b0;
    step();
    n_cmp++;
    if ({game_started, plot} !== 2'b00) begin
      n_bad++; $display("FAIL idle_hold: got %b expected 00", {game_started, plot});
    end
  endtask

  task automatic test_rounds();
    int ex[5] = '{10, 30, 50, 70, 0};
    int ey[5] = '{5, 15, 25, 35, 119};
    int ec[5] = '{1, 2, 3, 4, 7};
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if ({game_started, plot} !== 2'b10) begin
      n_bad++; $display("FAIL start_accept: got %b expected 10", {game_started, plot});
    end
    for (int n = 0; n < 15; n++) begin
      step();
      got = {plot, x, y, colour};
      exp = {1'b1, 8'(ex[n%5]), 7'(ey[n%5]), 3'(ec[n%5])};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL round_plot[%0d]: got %h expected %h", n, got, exp);
      end
    end
  endtask

  task automatic test_timer_expiry();
    int bar_bad = 0;
    for (int n = 1; n <= 159; n++) begin
      tick = 1'b1;
      step();
      if ((n-1) % 5 == 4) begin
        if ({plot, x, y, colour} !== {1'b1, 8'(n-1), 7'd119, 3'd7}) bar_bad++;
      end
      if (n == 158) begin
        n_cmp++;
        if (running !== 1'b1) begin
          n_bad++; $display("FAIL running_before_last_tick: got %b expected 1", running);
        end
      end
      if (n == 159) begin
        n_cmp++;
        if (running !== 1'b0) begin
          n_bad++; $display("FAIL running_after_last_tick: got %b expected 0", running);
        end
      end
    end
    tick = 1'b0;
    n_cmp++;
    if (bar_bad !== 0) begin
      n_bad++; $display("FAIL timer_bar_progress: got %0d bad plots expected 0", bar_bad);
    end
    step();
    n_cmp++;
    if ({plot, x, y, colour} !== {1'b1, 8'd159, 7'd119, 3'd7}) begin
      n_bad++; $display("FAIL final_timer_plot: got %h expected %h", {plot, x, y, colour}, {1'b1, 8'd159, 7'd119, 3'd7});
    end
    n_cmp++;
    if (dbg_state !== 3'd3) begin
      n_bad++; $display("FAIL enter_clear: got state %0d expected 3", dbg_state);
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < 5000; i++) step();
    n_cmp++;
    if ({plot, x, y, colour} !== {1'b1, 8'd39, 7'd31, 3'd0}) begin
      n_bad++; $display("FAIL clear_pixel_4999: got %h expected %h", {plot, x, y, colour}, {1'b1, 8'd39, 7'd31, 3'd0});
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if ({plot, x, y, colour} !== 19'd0) begin
      n_bad++; $display("FAIL mid_clear_reset_pixel: got %h expected 0", {plot, x, y, colour});
    end
    n_cmp++;
    if ({running, game_started, dbg_state} !== 5'b1_0_000) begin
      n_bad++; $display("FAIL mid_clear_reset_flags: got %b expected 10000", {running, game_started, dbg_state});
    end
    n_cmp++;
    if (dut.timer_x_q !== 8'd0) begin
      n_bad++; $display("FAIL mid_clear_reset_timer: got %0d expected 0", dut.timer_x_q);
    end
  endtask

  task automatic test_clear_full();
    int bad = 0;
    logic [18:0] first_got = '0, first_exp = '0;
    start = 1'b1; tick = 1'b1;
    for (int i = 0; i < 19200; i++) begin
      step();
      exp = {1'b1, 8'(i % 160), 7'(i / 160), 3'd0};
      if ({plot, x, y, colour} !== exp) begin
        if (bad == 0) begin first_got = {plot, x, y, colour}; first_exp = exp; end
        bad++;
      end
    end
    start = 1'b0; tick = 1'b0;
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL clear_raster: %0d bad plots, first got %h expected %h", bad, first_got, first_exp);
    end
    n_cmp++;
    if (dut.timer_x_q !== 8'd159) begin
      n_bad++; $display("FAIL tick_ignored_in_clear: got %0d expected 159", dut.timer_x_q);
    end
    n_cmp++;
    if (dbg_state !== 3'd4) begin
      n_bad++; $display("FAIL enter_box: got state %0d expected 4", dbg_state);
    end
  endtask

  task automatic test_box();
    int kc[4] = '{3, 2, 4, 1};
    int bad = 0, cnt = 0;
    rank = {3'd0, 3'd3, 3'd1, 3'd2};
    for (int k = 0; k < 4; k++)
      for (int dy = 0; dy < 7; dy++)
        for (int dx = 0; dx < 5; dx++) begin
          step();
          cnt++;
          exp = {1'b1, 8'(33 + 30*k + dx), 7'(42 + dy), 3'(kc[k])};
          if ({plot, x, y, colour} !== exp) bad++;
          if (cnt == 1) begin
            n_cmp++;
            if ({plot, x, y, colour} !== {1'b1, 8'd33, 7'd42, 3'd3}) begin
              n_bad++; $display("FAIL box_first: got %h expected %h", {plot, x, y, colour}, {1'b1, 8'd33, 7'd42, 3'd3});
            end
          end
          if (cnt == 140) begin
            n_cmp++;
            if ({plot, x, y, colour} !== {1'b1, 8'd127, 7'd48, 3'd1}) begin
              n_bad++; $display("FAIL box_last: got %h expected %h", {plot, x, y, colour}, {1'b1, 8'd127, 7'd48, 3'd1});
            end
          end
        end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL box_sequence: got %0d bad plots expected 0", bad);
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++; $display("FAIL done_after_box: got %b expected 1", done);
    end
    step();
    n_cmp++;
    if ({done, plot} !== 2'b10) begin
      n_bad++; $display("FAIL end_outputs: got %b expected 10", {done, plot});
    end
  endtask

  task automatic test_end_hold();
    int bad = 0;
    start = 1'b1; tick = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({done, plot, game_started} !== 3'b101) bad++;
    end
    start = 1'b0; tick = 1'b0;
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL end_ignores_start: got %0d bad cycles expected 0", bad);
    end
    n_cmp++;
    if (dut.timer_x_q !== 8'd159) begin
      n_bad++; $display("FAIL tick_ignored_in_end: got %0d expected 159", dut.timer_x_q);
    end
  endtask

  task automatic test_small_config();
    int ex[3] = '{3, 7, 0};
    int ey[3] = '{4, 9, 119};
    int ec[3] = '{5, 6, 7};
    int bc[2] = '{5, 0};
    int bad = 0, cnt = 0;
    reset2 = 1'b1; step(); reset2 = 1'b0;
    start2 = 1'b1; step(); start2 = 1'b0;
    for (int n = 0; n < 6; n++) begin
      step();
      got = {plot2, x2, y2, colour2};
      exp = {1'b1, 8'(ex[n%3]), 7'(ey[n%3]), 3'(ec[n%3])};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL small_round[%0d]: got %h expected %h", n, got, exp);
      end
    end
    for (int n = 1; n <= 63; n++) begin
      tick2 = 1'b1;
      step();
      if ((n-1) % 3 == 2 && {plot2, x2, y2, colour2} !== {1'b1, 8'(n-1), 7'd119, 3'd7}) bad++;
    end
    tick2 = 1'b0;
    n_cmp++;
    if (bad !== 0 || running2 !== 1'b0) begin
      n_bad++; $display("FAIL small_timer: got %0d bad plots running %b expected 0 and 0", bad, running2);
    end
    step(); step(); step();
    n_cmp++;
    if ({plot2, x2, y2, colour2} !== {1'b1, 8'd63, 7'd119, 3'd7} || dbg_state2 !== 3'd3) begin
      n_bad++; $display("FAIL small_last_round: got %h state %0d expected %h state 3", {plot2, x2, y2, colour2}, dbg_state2, {1'b1, 8'd63, 7'd119, 3'd7});
    end
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      step();
      if ({plot2, x2, y2, colour2} !== {1'b1, 8'(i % 64), 7'(i / 64), 3'd0}) bad++;
    end
    n_cmp++;
    if (bad !== 0 || dbg_state2 !== 3'd4) begin
      n_bad++; $display("FAIL small_clear: got %0d bad plots state %0d expected 0 state 4", bad, dbg_state2);
    end
    bad = 0;
    for (int k = 0; k < 2; k++)
      for (int dy = 0; dy < 7; dy++)
        for (int dx = 0; dx < 5; dx++) begin
          step();
          cnt++;
          if ({plot2, x2, y2, colour2} !== {1'b1, 8'(33 + 30*k + dx), 7'(42 + dy), 3'(bc[k])}) bad++;
        end
    n_cmp++;
    if (bad !== 0 || cnt !== 70) begin
      n_bad++; $display("FAIL small_box: got %0d bad of %0d expected 0 of 70", bad, cnt);
    end
    n_cmp++;
    if ({plot2, x2, y2, colour2} !== {1'b1, 8'd67, 7'd48, 3'd0}) begin
      n_bad++; $display("FAIL small_black_box_last: got %h expected %h", {plot2, x2, y2, colour2}, {1'b1, 8'd67, 7'd48, 3'd0});
    end
    step();
    n_cmp++;
    if ({done2, plot2} !== 2'b10) begin
      n_bad++; $display("FAIL small_end: got %b expected 10", {done2, plot2});
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      pos[i*15 +: 15]    = {8'(10 + 20*i), 7'(5 + 10*i)};
      pcolour[i*3 +: 3]  = 3'(i + 1);
    end
    rank     = {3'd3, 3'd2, 3'd1, 3'd0};
    pos2     = {8'd7, 7'd9, 8'd3, 7'd4};
    pcolour2 = {3'd6, 3'd5};
    rank2    = {3'd7, 3'd0};
    reset2 = 1'b1; start2 = 1'b0; tick2 = 1'b0;

    test_reset();
    test_rounds();
    test_timer_expiry();
    test_reset_mid_clear();
    test_rounds();
    test_timer_expiry();
    test_clear_full();
    test_box();
    test_end_hold();
    test_small_config();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
